cdc_fifo_write_arbiter: RTL and testbench

Round-robin arbiter that shares the write port of one clock-domain-crossing FIFO among `NUM_REQ` requesters in the FIFO's write clock domain. It grants the port in bursts and tags every beat with the requester ID. It throttles bursts using the FIFO's full flag and occupancy count, and releases stalled grants after a timeout. It sits between the write-side producers and the FIFO's `wr_en`/`wr_data`/`wr_full`/`wr_count` ports.

---
 rtl/cdc_fifo_write_arbiter_if.sv | 30 +++
 rtl/cdc_fifo_write_arbiter.sv | 131 +++++++++++++
 tb/tb_cdc_fifo_write_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdc_fifo_write_arbiter_if.sv
// Write-side bundle between the requesters, the arbiter and the CDC FIFO.
// master = arbiter, slave = requesters plus FIFO write port.
interface cdc_fifo_write_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH+ID_W-1:0]    fifo_wr_data;
  logic                          fifo_full;
  logic [ADDR_WIDTH:0]           fifo_wr_count;

  modport master (
    input  req_valid, req_data, req_last,
    input  fifo_full, fifo_wr_count,
    output req_ready, fifo_wr_en, fifo_wr_data
  );

  modport slave (
    output req_valid, req_data, req_last,
    output fifo_full, fifo_wr_count,
    input  req_ready, fifo_wr_en, fifo_wr_data
  );
endinterface

// File: rtl/cdc_fifo_write_arbiter.sv
// Round-robin burst arbiter for a shared CDC FIFO write port.
// Beats pass through combinationally; grants end on last, cap or timeout.
module cdc_fifo_write_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 4,
  parameter int MAX_BURST    = 8,
  parameter int START_SPACE  = 4,
  parameter int IDLE_TIMEOUT = 16,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  cdc_fifo_write_arbiter_if.master bus,
  output logic            burst_active,
  output logic [ID_W-1:0] grant_id,
  output logic            timeout_pulse
);

  localparam logic [ADDR_WIDTH:0] DEPTH =
    (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] SPACE =
    (ADDR_WIDTH+1)'(START_SPACE);
  localparam logic [7:0] MAXB = 8'(MAX_BURST);
  localparam logic [7:0] TMO  = 8'(IDLE_TIMEOUT);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] gid_q, gid_d;
  logic [ID_W-1:0] rr_q, rr_d;
  logic [7:0]      beat_q, beat_d;
  logic [7:0]      idle_q, idle_d;
  logic            tmo_q, tmo_d;

  logic [ADDR_WIDTH:0]   free;
  logic                  found;
  logic [ID_W-1:0]       pick, idx;
  logic                  vld_g, last_g, beat;
  logic [DATA_WIDTH-1:0] data_g;

  assign free   = DEPTH - bus.fifo_wr_count;
  assign vld_g  = bus.req_valid[gid_q];
  assign last_g = bus.req_last[gid_q];

  always_comb begin
    data_g = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gid_q == ID_W'(i))
        data_g = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Walk backwards so the closest valid after rr_q wins last.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(rr_q) + k) % NUM_REQ);
      if (bus.req_valid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    gid_d            = gid_q;
    rr_d             = rr_q;
    beat_d           = beat_q;
    idle_d           = idle_q;
    tmo_d            = 1'b0;
    beat             = 1'b0;
    bus.req_ready    = '0;
    bus.fifo_wr_en   = 1'b0;
    bus.fifo_wr_data = '0;
    unique case (state_q)
      S_IDLE: begin
        if (enable && found && free >= SPACE) begin
          state_d = S_BURST;
          gid_d   = pick;
          rr_d    = ID_W'((int'(pick) + 1) % NUM_REQ);
          beat_d  = '0;
          idle_d  = '0;
        end
      end
      S_BURST: begin
        bus.req_ready[gid_q] = !bus.fifo_full;
        beat             = vld_g && !bus.fifo_full;
        bus.fifo_wr_en   = beat;
        bus.fifo_wr_data = {gid_q, data_g};
        idle_d = vld_g ? 8'd0 : idle_q + 8'd1;
        if (beat) begin
          beat_d = beat_q + 8'd1;
          if (last_g || beat_d == MAXB)
            state_d = S_IDLE;
        end else if (!vld_g && idle_d == TMO) begin
          state_d = S_IDLE;
          tmo_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gid_q   <= '0;
      rr_q    <= '0;
      beat_q  <= '0;
      idle_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
      idle_q  <= idle_d;
      tmo_q   <= tmo_d;
    end
  end

  assign burst_active  = (state_q == S_BURST);
  assign grant_id      = gid_q;
  assign timeout_pulse = tmo_q;

endmodule

// File: tb/tb_cdc_fifo_write_arbiter.sv
// Directed bench for cdc_fifo_write_arbiter.
// Requester queues drive stimulus; a negedge monitor scores FIFO writes.
module tb_cdc_fifo_write_arbiter;
  localparam int NR  = 4;
  localparam int DW  = 32;
  localparam int AW  = 4;
  localparam int IDW = 2;

  typedef struct {
    logic [DW-1:0] d;
    logic          last;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           enable = 1'b0;
  logic           burst_active;
  logic [IDW-1:0] grant_id;
  logic           timeout_pulse;

  int cyc = 0;
  int total = 0;
  int passed = 0;
  int nwr = 0;
  int ntmo = 0;
  int wtime[$];
  int ttime[$];
  logic [DW+IDW-1:0] exp_q[$];
  beat_t rq[NR][$];

  cdc_fifo_write_arbiter_if #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
  ) bus ();

  cdc_fifo_write_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .MAX_BURST(8), .START_SPACE(4), .IDLE_TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .bus(bus),
    .burst_active(burst_active),
    .grant_id(grant_id),
    .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive();
    logic [NR-1:0]    v;
    logic [NR-1:0]    l;
    logic [NR*DW-1:0] d;
    v = '0;
    l = '0;
    d = '0;
    for (int i = 0; i < NR; i++) begin
      if (rq[i].size() > 0) begin
        v[i] = 1'b1;
        l[i] = rq[i][0].last;
        d[i*DW +: DW] = rq[i][0].d;
      end
    end
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
  endtask

  // Requester model: pop a beat after each accepted handshake.
  initial begin
    logic [NR-1:0] hs;
    drive();
    forever begin
      @(negedge clk);
      hs = bus.req_valid & bus.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++)
        if (hs[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      drive();
    end
  end

  // Scoreboard monitor.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (timeout_pulse) begin
        ntmo++;
        ttime.push_back(cyc);
        chk("tmo_burst_low", 64'(burst_active), 64'd0);
      end
      if (bus.fifo_wr_en) begin
        nwr++;
        wtime.push_back(cyc);
        chk("wr_id", 64'(bus.fifo_wr_data[DW +: IDW]), 64'(grant_id));
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL wr_unexpected: got %0h expected no write",
                   bus.fifo_wr_data);
        end else begin
          chk("wr_data", 64'(bus.fifo_wr_data), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(int r, int n, logic [DW-1:0] base,
                      int lastk, bit push);
    for (int k = 0; k < n; k++) begin
      rq[r].push_back('{d: base + DW'(k), last: (k == lastk)});
      if (push) exp_q.push_back({IDW'(r), base + DW'(k)});
    end
  endtask

  task automatic wait_writes(int target, int budget, string nm);
    int b = 0;
    while (nwr < target && b < budget) begin
      tick();
      b++;
    end
    chk(nm, 64'(nwr >= target), 64'd1);
  endtask

  task automatic drain(string nm);
    int b = 0;
    while ((exp_q.size() != 0 || burst_active) && b < 200) begin
      tick();
      b++;
    end
    chk(nm, 64'(exp_q.size() == 0 && !burst_active), 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    int t0;
    bus.fifo_full     = 1'b0;
    bus.fifo_wr_count = '0;
    #2;
    chk("rst_active", 64'(burst_active), 64'd0);
    chk("rst_gid", 64'(grant_id), 64'd0);
    chk("rst_tmo", 64'(timeout_pulse), 64'd0);
    chk("rst_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_wr_en", 64'(bus.fifo_wr_en), 64'd0);
    chk("rst_wr_data", 64'(bus.fifo_wr_data), 64'd0);
    tick(2);
    rst_n  = 1'b1;
    enable = 1'b1;
    tick();

    // Round-robin, single-beat bursts.
    base = nwr;
    for (int rep = 0; rep < 2; rep++)
      for (int r = 0; r < NR; r++)
        load(r, 1, 32'hA000_0000 + DW'(r * 16 + rep), 0, 1'b1);
    wait_writes(base + 8, 100, "rr_writes");
    for (int k = 1; k < 8; k++)
      chk("rr_gap", 64'(wtime[base+k] - wtime[base+k-1]), 64'd2);
    drain("rr_drain");

    // Burst cap: 20 beats split 8/8/4.
    base = nwr;
    load(2, 20, 32'hC000_0000, 19, 1'b1);
    wait_writes(base + 20, 200, "cap_writes");
    for (int k = 1; k < 20; k++)
      chk("cap_gap", 64'(wtime[base+k] - wtime[base+k-1]),
          (k % 8 == 0) ? 64'd2 : 64'd1);
    drain("cap_drain");

    // Backpressure for 5 cycles mid-burst.
    base = nwr;
    t0   = ntmo;
    load(1, 6, 32'hB000_0000, 5, 1'b1);
    wait_writes(base + 2, 50, "bp_start");
    bus.fifo_full = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_ready", 64'(bus.req_ready), 64'd0);
      chk("bp_wr_en", 64'(bus.fifo_wr_en), 64'd0);
      chk("bp_active", 64'(burst_active), 64'd1);
      @(posedge clk);
      #1;
    end
    bus.fifo_full = 1'b0;
    drain("bp_drain");
    chk("bp_writes", 64'(nwr - base), 64'd6);
    chk("bp_no_tmo", 64'(ntmo), 64'(t0));

    // Enable gate and admission threshold.
    base = nwr;
    enable = 1'b0;
    load(3, 1, 32'hD000_0000, 0, 1'b1);
    tick(4);
    chk("en_low_idle", 64'(burst_active), 64'd0);
    bus.fifo_wr_count = 5'd13;
    enable = 1'b1;
    tick(4);
    chk("adm_idle", 64'(burst_active), 64'd0);
    chk("adm_no_wr", 64'(nwr), 64'(base));
    bus.fifo_wr_count = 5'd12;
    tick();
    chk("adm_grant", 64'(burst_active), 64'd1);
    chk("adm_gid", 64'(grant_id), 64'd3);
    bus.fifo_wr_count = 5'd0;
    drain("adm_drain");

    // Idle timeout, then RR moves to requester 1.
    base = nwr;
    t0   = ntmo;
    load(0, 1, 32'hE000_0000, -1, 1'b1);
    load(1, 1, 32'hE100_0000, 0, 1'b1);
    wait_writes(base + 1, 50, "tmo_first");
    drain("tmo_drain");
    tick(3);
    chk("tmo_count", 64'(ntmo - t0), 64'd1);
    if (ntmo > t0 && wtime.size() >= base + 2) begin
      chk("tmo_delay", 64'(ttime[ttime.size()-1] - wtime[base]), 64'd17);
      chk("tmo_next", 64'(wtime[base+1] - wtime[base]), 64'd18);
    end

    // Reset after the third beat of a burst.
    base = nwr;
    load(2, 6, 32'hF000_0000, 5, 1'b0);
    for (int k = 0; k < 3; k++)
      exp_q.push_back({2'd2, 32'hF000_0000 + DW'(k)});
    wait_writes(base + 3, 50, "rstm_beats");
    rst_n = 1'b0;
    #1;
    chk("rstm_wr_en", 64'(bus.fifo_wr_en), 64'd0);
    chk("rstm_active", 64'(burst_active), 64'd0);
    chk("rstm_gid", 64'(grant_id), 64'd0);
    chk("rstm_ready", 64'(bus.req_ready), 64'd0);
    for (int i = 0; i < NR; i++) rq[i].delete();
    exp_q.delete();
    tick(2);
    chk("rstm_no_wr", 64'(nwr), 64'(base + 3));
    rst_n = 1'b1;
    load(0, 1, 32'h5000_0000, 0, 1'b1);
    load(3, 1, 32'h5300_0000, 0, 1'b1);
    wait_writes(base + 5, 50, "rstm_after");
    drain("rstm_drain");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
